clk_divider_multi: RTL and testbench

//  Multi-channel programmable clock divider; generalises the fixed single-output divider.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_channel.sv | 122 ++++++++++++
 rtl/clk_divider_multi.sv | 49 ++++
 tb/tb_clk_divider_multi.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
package clk_div_pkg;

   // Width of the channel-select field; never narrower than one bit.
   function automatic int ch_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // What a channel does on a given edge, highest priority first.
   typedef enum logic [2:0] {
      MODE_IDLE,
      MODE_ARM,
      MODE_RESTART,
      MODE_WRAP,
      MODE_COUNT
   } chan_mode_e;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: a period counter with a staged divisor that is only
// swapped in at a period boundary, so a reprogram never produces a runt pulse.
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int          CNT_W       = 16,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             restart,
   input  logic             we,
   input  logic [CNT_W-1:0] wdata,
   output logic             div_clk,
   output logic             tick,
   output logic             pend
);

   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W:0]   ONE_X   = (CNT_W + 1)'(1);

   typedef struct packed {
      logic             run;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] dact;
      logic [CNT_W-1:0] dpend;
      logic             pvalid;
   } chan_state_t;

   chan_state_t      st;
   chan_state_t      st_n;
   chan_mode_e       mode;
   logic             tick_n;
   logic             div_n;
   logic [CNT_W:0]   high_len;

   // Classify this edge; dact is nonzero whenever the wrap compare is reached.
   always_comb begin
      if (!en || st.dact == '0) begin
         mode = MODE_IDLE;
      end else if (!st.run) begin
         mode = MODE_ARM;
      end else if (restart) begin
         mode = MODE_RESTART;
      end else if (st.cnt == st.dact - ONE) begin
         mode = MODE_WRAP;
      end else begin
         mode = MODE_COUNT;
      end
   end

   // Next state and next outputs; outputs derive from the post-edge count and divisor.
   always_comb begin
      st_n     = st;
      tick_n   = 1'b0;
      div_n    = 1'b0;
      high_len = '0;
      case (mode)
         MODE_IDLE: begin
            st_n.run = 1'b0;
            st_n.cnt = '0;
            if (we) begin
               st_n.dact   = wdata;
               st_n.pvalid = 1'b0;
            end
         end
         MODE_ARM: begin
            st_n.run = 1'b1;
            st_n.cnt = '0;
            if (we) begin
               st_n.dact   = wdata;
               st_n.pvalid = 1'b0;
            end
         end
         MODE_RESTART, MODE_WRAP: begin
            st_n.cnt = '0;
            if (st.pvalid) begin
               st_n.dact   = st.dpend;
               st_n.pvalid = 1'b0;
            end
            if (we) begin
               st_n.dpend  = wdata;
               st_n.pvalid = 1'b1;
            end
         end
         default: begin
            st_n.cnt = st.cnt + ONE;
            if (we) begin
               st_n.dpend  = wdata;
               st_n.pvalid = 1'b1;
            end
         end
      endcase
      if (mode != MODE_IDLE) begin
         high_len = ({1'b0, st_n.dact} + ONE_X) >> 1;
         tick_n   = (st_n.cnt == st_n.dact - ONE);
         div_n    = ({1'b0, st_n.cnt} < high_len);
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st.run    <= 1'b0;
         st.cnt    <= '0;
         st.dact   <= DEF_DIV;
         st.dpend  <= '0;
         st.pvalid <= 1'b0;
         tick      <= 1'b0;
         div_clk   <= 1'b0;
      end else begin
         st      <= st_n;
         tick    <= tick_n;
         div_clk <= div_n;
      end
   end

   assign pend = st.pvalid;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: decodes divisor writes to the
// selected channel and broadcasts restart to every channel.
module clk_divider_multi
   import clk_div_pkg::*;
#(
   parameter int          N_CH        = 4,
   parameter int          CNT_W       = 16,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_CH-1:0]           en,
   input  logic                      restart,
   input  logic                      cfg_we,
   input  logic [ch_width(N_CH)-1:0] cfg_sel,
   input  logic [CNT_W-1:0]          cfg_div,
   output logic [N_CH-1:0]           div_clk,
   output logic [N_CH-1:0]           tick,
   output logic [N_CH-1:0]           pend
);

   logic [N_CH-1:0] we;

   // One write strobe per channel; selects beyond the last channel hit nothing.
   always_comb begin
      we = '0;
      for (int i = 0; i < N_CH; i++) begin
         we[i] = cfg_we && (int'(cfg_sel) == i);
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      clk_div_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .en      (en[g]),
         .restart (restart),
         .we      (we[g]),
         .wdata   (cfg_div),
         .div_clk (div_clk[g]),
         .tick    (tick[g]),
         .pend    (pend[g])
      );
   end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi: hand-computed vector table,
// directed corner sequences, and random traffic against a period model.
module tb_clk_divider_multi;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  en;
   logic        restart;
   logic        cfg_we;
   logic [1:0]  cfg_sel;
   logic [15:0] cfg_div;
   logic [3:0]  div_clk;
   logic [3:0]  tick;
   logic [3:0]  pend;

   int tests = 0;
   int fails = 0;

   // Model: per channel, position within the period and the divisor in force.
   int         m_run [4];
   int         m_pos [4];
   int         m_div [4];
   int         m_pnd [4];
   int         m_pv  [4];
   logic [3:0] e_tick;
   logic [3:0] e_div;
   logic [3:0] e_pend;

   typedef struct {
      logic [3:0]  en;
      logic        we;
      logic [1:0]  sel;
      logic [15:0] div;
      logic [3:0]  tick;
      logic [3:0]  dclk;
   } vec_t;

   vec_t vecs [12];

   clk_divider_multi #(
      .N_CH        (4),
      .CNT_W       (16),
      .DEFAULT_DIV (2)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .restart (restart),
      .cfg_we  (cfg_we),
      .cfg_sel (cfg_sel),
      .cfg_div (cfg_div),
      .div_clk (div_clk),
      .tick    (tick),
      .pend    (pend)
   );

   // Free-running 10-unit system clock.
   always #5 clk = ~clk;

   task automatic check_vec(input string name, input logic [3:0] act, input logic [3:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_run[i] = 0;
         m_pos[i] = 0;
         m_div[i] = 2;
         m_pnd[i] = 0;
         m_pv[i]  = 0;
      end
      e_tick = '0;
      e_div  = '0;
      e_pend = '0;
   endtask

   task automatic model_edge();
      if (!reset) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 4; i++) begin
         bit w;
         w = cfg_we && (int'(cfg_sel) == i);
         if (!en[i] || m_div[i] == 0) begin
            m_run[i] = 0;
            m_pos[i] = 0;
            if (w) begin
               m_div[i] = int'(cfg_div);
               m_pv[i]  = 0;
            end
            e_tick[i] = 1'b0;
            e_div[i]  = 1'b0;
         end else begin
            if (m_run[i] == 0) begin
               m_run[i] = 1;
               m_pos[i] = 0;
               if (w) begin
                  m_div[i] = int'(cfg_div);
                  m_pv[i]  = 0;
               end
            end else if (restart || m_pos[i] == m_div[i] - 1) begin
               m_pos[i] = 0;
               if (m_pv[i] != 0) begin
                  m_div[i] = m_pnd[i];
                  m_pv[i]  = 0;
               end
               if (w) begin
                  m_pnd[i] = int'(cfg_div);
                  m_pv[i]  = 1;
               end
            end else begin
               m_pos[i]++;
               if (w) begin
                  m_pnd[i] = int'(cfg_div);
                  m_pv[i]  = 1;
               end
            end
            e_tick[i] = (m_pos[i] == m_div[i] - 1);
            e_div[i]  = (m_pos[i] < (m_div[i] + 1) / 2);
         end
         e_pend[i] = (m_pv[i] != 0);
      end
   endtask

   task automatic check_output(input string name);
      check_vec({name, "_tick"}, tick, e_tick);
      check_vec({name, "_div_clk"}, div_clk, e_div);
      check_vec({name, "_pend"}, pend, e_pend);
   endtask

   task automatic apply_stimulus(input string name, input logic [3:0] e, input logic rs,
                                 input logic w, input logic [1:0] s, input logic [15:0] d);
      en      = e;
      restart = rs;
      cfg_we  = w;
      cfg_sel = s;
      cfg_div = d;
      @(posedge clk);
      model_edge();
      #1;
      check_output(name);
      restart = 1'b0;
      cfg_we  = 1'b0;
   endtask

   initial begin
      logic [3:0]  en_r;
      logic        rs_r;
      logic        we_r;
      logic [1:0]  sel_r;
      logic [15:0] div_r;

      vecs[0]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0001};
      vecs[1]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000};
      vecs[2]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0001};
      vecs[3]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000};
      vecs[4]  = '{4'b0001, 1'b1, 2'd1, 16'd5, 4'b0000, 4'b0001};
      vecs[5]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0010};
      vecs[6]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0011};
      vecs[7]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0010};
      vecs[8]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0001};
      vecs[9]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0011, 4'b0000};
      vecs[10] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0011};
      vecs[11] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0010};

      reset   = 1'b0;
      en      = '0;
      restart = 1'b0;
      cfg_we  = 1'b0;
      cfg_sel = '0;
      cfg_div = '0;
      model_reset();

      // Reset state.
      repeat (2) apply_stimulus("reset", 4'b0000, 1'b0, 1'b0, 2'd0, 16'd0);
      check_vec("reset_tick_zero", tick, 4'b0000);
      check_vec("reset_div_zero", div_clk, 4'b0000);
      reset = 1'b1;

      // Default divide-by-2 on ch0, then program ch1 to 5 while idle and enable it.
      for (int v = 0; v < 12; v++) begin
         apply_stimulus("table", vecs[v].en, 1'b0, vecs[v].we, vecs[v].sel, vecs[v].div);
         check_vec($sformatf("table%0d_tick", v), tick, vecs[v].tick);
         check_vec($sformatf("table%0d_div", v), div_clk, vecs[v].dclk);
      end

      // Staged reload on ch1: current 5-cycle period completes, then 3-cycle periods.
      apply_stimulus("reload_wr", 4'b0011, 1'b0, 1'b1, 2'd1, 16'd3);
      check_bit("reload_pend_set", pend[1], 1'b1);
      apply_stimulus("reload", 4'b0011, 1'b0, 1'b0, 2'd0, 16'd0);
      apply_stimulus("reload", 4'b0011, 1'b0, 1'b0, 2'd0, 16'd0);
      check_bit("reload_old_tick", tick[1], 1'b1);
      check_bit("reload_pend_held", pend[1], 1'b1);
      apply_stimulus("reload", 4'b0011, 1'b0, 1'b0, 2'd0, 16'd0);
      check_bit("reload_pend_clr", pend[1], 1'b0);
      apply_stimulus("reload", 4'b0011, 1'b0, 1'b0, 2'd0, 16'd0);
      check_bit("reload_mid", tick[1], 1'b0);
      apply_stimulus("reload", 4'b0011, 1'b0, 1'b0, 2'd0, 16'd0);
      check_bit("reload_new_tick", tick[1], 1'b1);

      // Restart re-phases ch0 (D=4) and ch2 (D=6) running out of phase.
      apply_stimulus("rst_setup", 4'b0000, 1'b0, 1'b0, 2'd0, 16'd0);
      apply_stimulus("rst_setup", 4'b0000, 1'b0, 1'b1, 2'd0, 16'd4);
      apply_stimulus("rst_setup", 4'b0000, 1'b0, 1'b1, 2'd2, 16'd6);
      apply_stimulus("rst_setup", 4'b0001, 1'b0, 1'b0, 2'd0, 16'd0);
      apply_stimulus("rst_setup", 4'b0001, 1'b0, 1'b0, 2'd0, 16'd0);
      apply_stimulus("rst_setup", 4'b0101, 1'b0, 1'b0, 2'd0, 16'd0);
      apply_stimulus("rst_setup", 4'b0101, 1'b0, 1'b0, 2'd0, 16'd0);
      apply_stimulus("restart", 4'b0101, 1'b1, 1'b0, 2'd0, 16'd0);
      check_vec("restart_no_tick", tick & 4'b0101, 4'b0000);
      check_vec("restart_div_high", div_clk & 4'b0101, 4'b0101);
      for (int k = 1; k <= 5; k++) begin
         apply_stimulus("after_restart", 4'b0101, 1'b0, 1'b0, 2'd0, 16'd0);
         if (k == 3) check_bit("restart_ch0_tick", tick[0], 1'b1);
         if (k == 5) check_bit("restart_ch2_tick", tick[2], 1'b1);
      end

      // Divisor 0 on running ch0: period completes, then silence; then divide-by-1.
      apply_stimulus("zero_wr", 4'b0101, 1'b0, 1'b1, 2'd0, 16'd0);
      apply_stimulus("zero_fin", 4'b0101, 1'b0, 1'b0, 2'd0, 16'd0);
      check_bit("zero_last_tick", tick[0], 1'b1);
      apply_stimulus("zero_fin", 4'b0101, 1'b0, 1'b0, 2'd0, 16'd0);
      for (int k = 0; k < 4; k++) begin
         apply_stimulus("zero_idle", 4'b0101, 1'b0, 1'b0, 2'd0, 16'd0);
         check_bit("zero_tick_low", tick[0], 1'b0);
         check_bit("zero_div_low", div_clk[0], 1'b0);
      end
      apply_stimulus("one_wr", 4'b0101, 1'b0, 1'b1, 2'd0, 16'd1);
      for (int k = 0; k < 4; k++) begin
         apply_stimulus("one_run", 4'b0101, 1'b0, 1'b0, 2'd0, 16'd0);
         check_bit("one_tick_high", tick[0], 1'b1);
         check_bit("one_div_high", div_clk[0], 1'b1);
      end

      // Asynchronous reset mid-period drops a pending write.
      apply_stimulus("areset_wr", 4'b0101, 1'b0, 1'b1, 2'd2, 16'd2);
      check_bit("areset_pend_set", pend[2], 1'b1);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_vec("areset_tick", tick, 4'b0000);
      check_vec("areset_div", div_clk, 4'b0000);
      check_vec("areset_pend", pend, 4'b0000);
      apply_stimulus("areset_hold", 4'b0101, 1'b0, 1'b0, 2'd0, 16'd0);
      reset = 1'b1;
      apply_stimulus("post_reset", 4'b0001, 1'b0, 1'b0, 2'd0, 16'd0);
      check_bit("post_reset_arm_div", div_clk[0], 1'b1);
      apply_stimulus("post_reset", 4'b0001, 1'b0, 1'b0, 2'd0, 16'd0);
      check_bit("post_reset_tick", tick[0], 1'b1);
      check_vec("post_reset_pend", pend, 4'b0000);

      // Random traffic against the model.
      en_r = 4'b1111;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 15) == 0) en_r = 4'($urandom);
         rs_r  = ($urandom_range(0, 24) == 0);
         we_r  = ($urandom_range(0, 3) == 0);
         sel_r = 2'($urandom);
         case ($urandom_range(0, 9))
            0:       div_r = 16'd0;
            1:       div_r = 16'd1;
            2:       div_r = 16'($urandom_range(8, 40));
            default: div_r = 16'($urandom_range(2, 7));
         endcase
         apply_stimulus("random", en_r, rs_r, we_r, sel_r, div_r);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
